// File: rtl/seq_scan_ctrl_if.sv
// seq_scan_ctrl_if: word-input and frame-result handshakes of the sequence scanner.
//   in_valid/in_ready/in_data/in_last : one input word per transfer, MSB scanned first
//   out_valid/out_ready/out_count     : per-frame match count, held until taken
// master = producer/consumer side (testbench or upstream), slave = the scanner.
interface seq_scan_ctrl_if #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_count
   );
endinterface

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: counts occurrences of a 2..4 bit pattern in a serial bit stream built from
// a frame of words (MSB first); matches may span words and optionally overlap.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cfg_pattern_i     : target pattern, bit 0 = most recently shifted bit
//   cfg_len_i         : pattern length (0/1 -> 2, 5..7 -> 4)
//   cfg_overlap_i     : 1 = overlapping matches counted
//   bus (slave)       : word input handshake and frame result handshake
//   match_pulse_o     : one-cycle strobe per match
//   busy_o            : frame in progress (word accepted, result not yet taken)
module seq_scan_ctrl #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned CNT_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       cfg_pattern_i,
   input  logic [2:0]       cfg_len_i,
   input  logic             cfg_overlap_i,
   seq_scan_ctrl_if.slave   bus,
   output logic             match_pulse_o,
   output logic             busy_o
);

   localparam int unsigned BitCntW = (WORD_W > 2) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                last_q, last_d;
   logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
   // Three stored bits plus the bit being shifted form the 4-bit history window.
   logic [2:0]          hist_q, hist_d;
   logic [2:0]          seen_q, seen_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                match_q, match_d;
   logic                busy_q, busy_d;
   logic [3:0]          pat_q, pat_d;
   logic [2:0]          len_q, len_d;
   logic                ovl_q, ovl_d;

   logic [3:0]          hist_win;
   logic [2:0]          seen_inc;
   logic [3:0]          len_mask;
   logic [2:0]          len_norm;
   logic                hit;
   logic                in_ready;
   logic                out_valid;

   always_comb begin
      if (cfg_len_i < 3'd2) begin
         len_norm = 3'd2;
      end else if (cfg_len_i > 3'd4) begin
         len_norm = 3'd4;
      end else begin
         len_norm = cfg_len_i;
      end
   end

   always_comb begin
      hist_win = {hist_q, data_q[WORD_W-1]};
      seen_inc = (seen_q >= 3'd4) ? 3'd4 : seen_q + 3'd1;
      unique case (len_q)
         3'd2:    len_mask = 4'b0011;
         3'd3:    len_mask = 4'b0111;
         default: len_mask = 4'b1111;
      endcase
      hit = (seen_inc >= len_q) && ((hist_win & len_mask) == (pat_q & len_mask));
   end

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      last_d    = last_q;
      bit_cnt_d = bit_cnt_q;
      hist_d    = hist_q;
      seen_d    = seen_q;
      count_d   = count_q;
      match_d   = 1'b0;
      busy_d    = busy_q;
      pat_d     = pat_q;
      len_d     = len_q;
      ovl_d     = ovl_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               data_d    = bus.in_data;
               last_d    = bus.in_last;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               // Configuration is frozen for the whole frame at its first word.
               if (!busy_q) begin
                  pat_d = cfg_pattern_i;
                  len_d = len_norm;
                  ovl_d = cfg_overlap_i;
               end
               state_d = StShift;
            end
         end

         StShift: begin
            data_d    = data_q << 1;
            hist_d    = hist_win[2:0];
            seen_d    = seen_inc;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (hit) begin
               match_d = 1'b1;
               if (count_q != {CNT_W{1'b1}}) begin
                  count_d = count_q + 1'b1;
               end
               if (!ovl_q) begin
                  seen_d = 3'd0;
               end
            end
            if (bit_cnt_q == BitCntW'(WORD_W - 1)) begin
               state_d = last_q ? StReport : StIdle;
            end
         end

         StReport: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               count_d = '0;
               hist_d  = '0;
               seen_d  = '0;
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         data_q    <= '0;
         last_q    <= 1'b0;
         bit_cnt_q <= '0;
         hist_q    <= '0;
         seen_q    <= '0;
         count_q   <= '0;
         match_q   <= 1'b0;
         busy_q    <= 1'b0;
         pat_q     <= '0;
         len_q     <= 3'd2;
         ovl_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         data_q    <= data_d;
         last_q    <= last_d;
         bit_cnt_q <= bit_cnt_d;
         hist_q    <= hist_d;
         seen_q    <= seen_d;
         count_q   <= count_d;
         match_q   <= match_d;
         busy_q    <= busy_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         ovl_q     <= ovl_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid;
   assign bus.out_count  = count_q;
   assign match_pulse_o  = match_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: scoreboard bench for seq_scan_ctrl. The driver feeds words and a
// window-based reference model pushes expected pulse cycles and frame results; a monitor
// on the falling edge pops and compares whenever the DUT strobes or presents a result.
module tb_seq_scan_ctrl;
   localparam int unsigned WORD_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int MaxCnt = (1 << CNT_W) - 1;

   typedef struct {
      int cnt;
      int vcyc;
   } res_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] cfg_pattern = '0;
   logic [2:0] cfg_len = 3'd2;
   logic       cfg_overlap = 1'b0;
   logic       match_pulse;
   logic       busy;
   logic       rand_rdy = 1'b1;

   seq_scan_ctrl_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

   seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .cfg_pattern_i (cfg_pattern),
      .cfg_len_i     (cfg_len),
      .cfg_overlap_i (cfg_overlap),
      .bus           (bus),
      .match_pulse_o (match_pulse),
      .busy_o        (busy)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   res_t res_q[$];
   int pulse_q[$];
   int pulses_seen = 0;
   int last_taken = -1;
   bit prev_valid = 1'b0;

   // Reference model state for the frame in flight.
   bit         bits[$];
   int         start_idx;
   int         nmatch;
   logic [3:0] m_pat;
   int         m_len;
   bit         m_ovl;
   bit         in_frame = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int norm_len(input logic [2:0] l);
      if (l < 2) return 2;
      if (l > 4) return 4;
      return int'(l);
   endfunction

   // Extends the frame's bit string and records every window that matches the pattern.
   task automatic model_word(input logic [WORD_W-1:0] d, input bit last, input int acc);
      int j;
      bit ok;
      if (!in_frame) begin
         m_pat = cfg_pattern;
         m_len = norm_len(cfg_len);
         m_ovl = cfg_overlap;
         bits.delete();
         start_idx = 0;
         nmatch = 0;
         in_frame = 1'b1;
      end
      for (int i = 0; i < int'(WORD_W); i++) begin
         bits.push_back(d[WORD_W-1-i]);
         j = bits.size() - 1;
         if (j - start_idx + 1 >= m_len) begin
            ok = 1'b1;
            for (int k = 0; k < m_len; k++) begin
               if (bits[j-k] != m_pat[k]) ok = 1'b0;
            end
            if (ok) begin
               nmatch++;
               pulse_q.push_back(acc + 1 + i);
               if (!m_ovl) start_idx = j + 1;
            end
         end
      end
      if (last) begin
         res_q.push_back('{cnt: (nmatch > MaxCnt) ? MaxCnt : nmatch, vcyc: acc + int'(WORD_W)});
         in_frame = 1'b0;
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
      end else begin
         if (match_pulse) begin
            pulses_seen++;
            if (pulse_q.size() == 0) check("unexpected_pulse", cyc, -1);
            else check("pulse_cycle", cyc, pulse_q.pop_front());
         end
         if (bus.out_valid) begin
            if (res_q.size() == 0) begin
               check("unexpected_out_valid", 1, 0);
            end else begin
               if (!prev_valid) check("out_valid_rise_cycle", cyc, res_q[0].vcyc);
               check("out_count", int'(bus.out_count), res_q[0].cnt);
               check("in_ready_in_report", int'(bus.in_ready), 0);
               if (bus.out_ready) begin
                  last_taken = int'(bus.out_count);
                  void'(res_q.pop_front());
               end
            end
         end
         prev_valid = bus.out_valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send_word(input logic [WORD_W-1:0] d, input bit last);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      while (!bus.in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.in_ready) begin
         check("in_ready_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      model_word(d, last, cyc + 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = WORD_W'($urandom);
      // Mid-frame configuration changes must be ignored.
      cfg_pattern = 4'($urandom);
      cfg_len     = 3'($urandom);
      cfg_overlap = 1'($urandom);
   endtask

   task automatic set_cfg(input logic [3:0] p, input logic [2:0] l, input bit o);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((res_q.size() != 0 || !bus.in_ready) && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 400) check("frame_done_timeout", 0, 1);
      check("pulses_all_seen", pulse_q.size(), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, int'(bus.in_ready), 1);
      check({tag, "_out_valid"}, int'(bus.out_valid), 0);
      check({tag, "_out_count"}, int'(bus.out_count), 0);
      check({tag, "_match_pulse"}, int'(match_pulse), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      res_q.delete();
      pulse_q.delete();
      in_frame = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("after_reset");
   endtask

   initial begin
      int nw;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Overlapping matches in 10101010.
      pulses_seen = 0;
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'hAA, 1'b1);
      wait_done();
      check("overlap_pulses", pulses_seen, 3);
      check("overlap_count", last_taken, 3);

      // Same stream without overlap.
      pulses_seen = 0;
      set_cfg(4'b0101, 3'd3, 1'b0);
      send_word(8'hAA, 1'b1);
      wait_done();
      check("nonoverlap_pulses", pulses_seen, 2);
      check("nonoverlap_count", last_taken, 2);

      // Match spanning a word boundary; frame stays busy between words.
      pulses_seen = 0;
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'h02, 1'b0);
      repeat (WORD_W) @(posedge clk);
      #1;
      check("span_idle_in_ready", int'(bus.in_ready), 1);
      check("span_idle_busy", int'(busy), 1);
      check("span_idle_out_valid", int'(bus.out_valid), 0);
      send_word(8'h80, 1'b1);
      wait_done();
      check("span_pulses", pulses_seen, 1);
      check("span_count", last_taken, 1);

      // Counter saturation.
      pulses_seen = 0;
      set_cfg(4'b0011, 3'd2, 1'b1);
      send_word(8'hFF, 1'b0);
      send_word(8'hFF, 1'b0);
      send_word(8'hFF, 1'b1);
      wait_done();
      check("sat_pulses", pulses_seen, 23);
      check("sat_count", last_taken, 15);

      // Backpressure in REPORT with a word pending on the input.
      rand_rdy = 1'b0;
      bus.out_ready = 1'b0;
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'hAA, 1'b1);
      nw = 0;
      while (!bus.out_valid && nw < 50) begin
         @(posedge clk);
         #1;
         nw++;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", int'(bus.out_valid), 1);
         check("bp_out_count", int'(bus.out_count), 3);
         check("bp_in_ready", int'(bus.in_ready), 0);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_taken_out_valid", int'(bus.out_valid), 0);
      check("bp_taken_out_count", int'(bus.out_count), 0);
      check("bp_taken_in_ready", int'(bus.in_ready), 1);
      check("bp_taken_busy", int'(busy), 0);
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'h00, 1'b1);
      rand_rdy = 1'b1;
      wait_done();

      // Reset in the middle of SHIFT, then a clean frame.
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'hAA, 1'b1);
      @(posedge clk);
      #1;
      do_reset();
      pulses_seen = 0;
      set_cfg(4'b0101, 3'd3, 1'b1);
      send_word(8'hAA, 1'b1);
      wait_done();
      check("post_reset_pulses", pulses_seen, 3);
      check("post_reset_count", last_taken, 3);

      // Randomised frames, including out-of-range lengths.
      for (int f = 0; f < 40; f++) begin
         set_cfg(4'($urandom), 3'($urandom), 1'($urandom));
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            send_word(WORD_W'($urandom), (w == nw - 1));
            if ($urandom_range(0, 2) == 0) begin
               repeat ($urandom_range(1, 12)) @(posedge clk);
               #1;
            end
         end
         wait_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
